// File: rtl/lia_readout_sched.sv
// rtl/lia_readout_sched.sv - snapshots all lock-in channel X/Y results at a decimated tick and hands them to the CPU one channel at a time
// Optional visit mask: define LIA_SCHED_CH_MASK_EN to add the ch_mask port.
module lia_readout_sched #(
    parameter int NCH     = 8,
    parameter int DW      = 16,
    parameter int DECIM_W = 16,
    parameter int CW      = $clog2(NCH)
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NCH*DW-1:0]  lia_x,
    input  logic [NCH*DW-1:0]  lia_y,
    input  logic               run,
    input  logic [DECIM_W-1:0] decim,
    input  logic               cpu_ack,
    input  logic               clr_ovr,
`ifdef LIA_SCHED_CH_MASK_EN
    input  logic [NCH-1:0]     ch_mask,
`endif
    output logic [DW-1:0]      out_x,
    output logic [DW-1:0]      out_y,
    output logic [CW-1:0]      out_ch,
    output logic               out_valid,
    output logic               overrun,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DECIM_W-1:0]  cnt_q, cnt_d;
    logic [NCH*DW-1:0]   shadow_x_q, shadow_x_d;
    logic [NCH*DW-1:0]   shadow_y_q, shadow_y_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [DW-1:0]       out_x_q, out_x_d;
    logic [DW-1:0]       out_y_q, out_y_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [NCH-1:0]      tick_mask;
    logic [NCH-1:0]      act_mask;
    logic [DECIM_W-1:0]  decim_m1;
    logic                tick;
    logic                first_ok, nxt_ok;
    logic [CW-1:0]       first_ch, nxt_ch;

`ifdef LIA_SCHED_CH_MASK_EN
    logic [NCH-1:0]      mask_q, mask_d;
    assign tick_mask = ch_mask;
    assign act_mask  = mask_q;
`else
    localparam logic [NCH-1:0] ALL_CH = '1;
    assign tick_mask = ALL_CH;
    assign act_mask  = ALL_CH;
`endif

    // Lowest channel at or above start whose mask bit is set; MSB flags a hit.
    function automatic logic [CW:0] find_from(input logic [NCH-1:0] m, input int start);
        logic [CW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= start && m[i]) begin
                r = {1'b1, CW'(i)};
            end
        end
        return r;
    endfunction

    // >= rather than == so a smaller decim takes effect without waiting for a wrap.
    assign decim_m1 = (decim == '0) ? '0 : decim - DECIM_W'(1);
    assign tick     = (cnt_q >= decim_m1);

    assign {first_ok, first_ch} = find_from(tick_mask, 0);
    assign {nxt_ok, nxt_ch}     = find_from(act_mask, int'(ch_q) + 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        ch_d       = ch_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q & ~clr_ovr;
`ifdef LIA_SCHED_CH_MASK_EN
        mask_d     = mask_q;
`endif

        if (!run || state_q == S_IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DECIM_W'(1);
        end

        if (!run) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (tick) begin
                        shadow_x_d = lia_x;
                        shadow_y_d = lia_y;
`ifdef LIA_SCHED_CH_MASK_EN
                        mask_d     = ch_mask;
`endif
                        if (first_ok) begin
                            ch_d    = first_ch;
                            out_x_d = lia_x[int'(first_ch)*DW +: DW];
                            out_y_d = lia_y[int'(first_ch)*DW +: DW];
                            valid_d = 1'b1;
                            state_d = S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    // A tick here is dropped; the set overrides a same-cycle clear.
                    if (tick) begin
                        overrun_d = 1'b1;
                    end
                    if (cpu_ack) begin
                        if (nxt_ok) begin
                            ch_d    = nxt_ch;
                            out_x_d = shadow_x_q[int'(nxt_ch)*DW +: DW];
                            out_y_d = shadow_y_q[int'(nxt_ch)*DW +: DW];
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            ch_q       <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef LIA_SCHED_CH_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            ch_q       <= ch_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef LIA_SCHED_CH_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == S_PRESENT);

endmodule

// File: tb/tb_lia_readout_sched.sv
// tb/tb_lia_readout_sched.sv - scoreboard bench for lia_readout_sched
module tb_lia_readout_sched;

    localparam int NCH     = 8;
    localparam int DW      = 16;
    localparam int DECIM_W = 16;
    localparam int CW      = $clog2(NCH);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH*DW-1:0]  lia_x = '0;
    logic [NCH*DW-1:0]  lia_y = '0;
    logic               run = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic               cpu_ack = 1'b0;
    logic               clr_ovr = 1'b0;
`ifdef LIA_SCHED_CH_MASK_EN
    logic [NCH-1:0]     ch_mask = '1;
`endif
    logic [DW-1:0]      out_x;
    logic [DW-1:0]      out_y;
    logic [CW-1:0]      out_ch;
    logic               out_valid;
    logic               overrun;
    logic               busy;

    lia_readout_sched #(.NCH(NCH), .DW(DW), .DECIM_W(DECIM_W)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .lia_x         (lia_x),
        .lia_y         (lia_y),
        .run           (run),
        .decim         (decim),
        .cpu_ack       (cpu_ack),
        .clr_ovr       (clr_ovr),
`ifdef LIA_SCHED_CH_MASK_EN
        .ch_mask       (ch_mask),
`endif
        .out_x         (out_x),
        .out_y         (out_y),
        .out_ch        (out_ch),
        .out_valid     (out_valid),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } ent_t;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_lia();
        for (int i = 0; i < NCH; i++) begin
            lia_x[i*DW +: DW] = DW'($urandom);
            lia_y[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic push_frame(input logic [NCH-1:0] m);
        ent_t e;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                e.ch = CW'(i);
                e.x  = lia_x[i*DW +: DW];
                e.y  = lia_y[i*DW +: DW];
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_present(input string tag);
        ent_t e;
        if (out_valid) begin
            chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk({tag, "_ch"}, 64'(out_ch), 64'(e.ch));
                chk({tag, "_x"},  64'(out_x),  64'(e.x));
                chk({tag, "_y"},  64'(out_y),  64'(e.y));
            end
        end
    endtask

    task automatic drive_ack(input logic a);
        cpu_ack = a && out_valid;
        if (cpu_ack && sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_out_x", 64'(out_x), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();

        // decim=10, prompt acks, then run dropped mid-frame at channel 3
        decim = 16'd10;
        run   = 1'b1;
        new_lia();
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 10) chk("t1_lat_pre", 64'(out_valid), 64'd0);
            if (c == 11) chk("t1_lat", 64'(out_valid), 64'd1);
            if (c == 19) begin
                chk("t1_wait_valid", 64'(out_valid), 64'd0);
                chk("t1_wait_busy", 64'(busy), 64'd0);
            end
            if (c == 24) begin
                chk("t1_ch3", 64'(out_ch), 64'd3);
                chk("t1_ovr", 64'(overrun), 64'd0);
            end
            check_present("t1");
            drive_ack(c < 24);
            if (c == 24) run = 1'b0;
            new_lia();
            if (c == 10 || c == 20) push_frame('1);
        end
        step();
        chk("t1_stop_valid", 64'(out_valid), 64'd0);
        chk("t1_stop_ch", 64'(out_ch), 64'd3);
        chk("t1_stop_busy", 64'(busy), 64'd0);
        sb.delete();

        // Restart with decim=0: frame appears on the 2nd cycle
        decim = '0;
        run   = 1'b1;
        new_lia();
        step();
        chk("t2_pre", 64'(out_valid), 64'd0);
        new_lia();
        push_frame('1);
        step();
        chk("t2_valid", 64'(out_valid), 64'd1);
        check_present("t2");
        new_lia();
        step();
        chk("t2_ovr", 64'(overrun), 64'd1);
        run = 1'b0;
        step();
        sb.delete();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("t2_clr", 64'(overrun), 64'd0);

        // decim=4, never ack; clear in a tick cycle loses to the set
        decim = 16'd4;
        run   = 1'b1;
        new_lia();
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 5) chk("t3_valid", 64'(out_valid), 64'd1);
            if (c == 8) chk("t3_ovr_pre", 64'(overrun), 64'd0);
            if (c == 9) begin
                chk("t3_ovr", 64'(overrun), 64'd1);
                chk("t3_hold_ch", 64'(out_ch), 64'd0);
            end
            if (c == 13) chk("t3_clr_in_tick", 64'(overrun), 64'd1);
            if (c == 14) chk("t3_clr", 64'(overrun), 64'd0);
            check_present("t3");
            clr_ovr = (c == 12 || c == 13);
            new_lia();
            if (c == 4) push_frame('1);
        end
        clr_ovr = 1'b0;
        run = 1'b0;
        step();
        sb.delete();

        // Last ack coinciding with a tick, then last ack one cycle before a tick
        decim = 16'd10;
        run   = 1'b1;
        new_lia();
        for (int c = 1; c <= 42; c++) begin
            step();
            if (c == 21) begin
                chk("t4_drop_valid", 64'(out_valid), 64'd0);
                chk("t4_drop_ovr", 64'(overrun), 64'd1);
            end
            if (c == 23) chk("t4_clr", 64'(overrun), 64'd0);
            if (c == 30) chk("t4_no_frame", 64'(out_valid), 64'd0);
            if (c == 31) chk("t4_frame2", 64'(out_valid), 64'd1);
            if (c == 40) chk("t4_wait", 64'(out_valid), 64'd0);
            if (c == 41) begin
                chk("t4_frame3", 64'(out_valid), 64'd1);
                chk("t4_ovr_clean", 64'(overrun), 64'd0);
            end
            check_present("t4");
            drive_ack((c >= 13 && c <= 20) || (c >= 32 && c <= 39));
            clr_ovr = (c == 22);
            new_lia();
            if (c == 10 || c == 30 || c == 40) push_frame('1);
        end
        cpu_ack = 1'b0;
        clr_ovr = 1'b0;
        run = 1'b0;
        step();
        sb.delete();

`ifdef LIA_SCHED_CH_MASK_EN
        // Masked frame visits 2,5,7; an all-zero mask produces no frames
        decim   = 16'd8;
        ch_mask = 8'b1010_0100;
        run     = 1'b1;
        new_lia();
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c == 9)  chk("t5_first_ch", 64'(out_ch), 64'd2);
            if (c == 12) chk("t5_done", 64'(out_valid), 64'd0);
            if (c == 17 || c == 25 || c == 33) chk("t5_zero_mask", 64'(out_valid), 64'd0);
            if (c == 34) chk("t5_ovr", 64'(overrun), 64'd0);
            check_present("t5");
            drive_ack(1'b1);
            if (c == 12) ch_mask = '0;
            new_lia();
            if (c == 8) push_frame(ch_mask);
        end
        cpu_ack = 1'b0;
        run = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lia_readout_sched.md
# lia_readout_sched

Readout scheduler sharing the single CPU-facing lock-in result port pair (16-bit X and 16-bit Y PIO inputs) among the NCH lock-in channels. At a programmable decimation rate it snapshots the X/Y outputs of all channels in one cycle. It then presents the snapshot one channel at a time, handing each channel to the CPU with a valid/ack handshake. It sits between the lock-in datapath and the Qsys PIO inputs, with run, decimation and flag-clear driven from Qsys output PIOs.

## Interface
Parameters:
- NCH, 8, number of lock-in channels (≥2)
- DW, 16, X/Y sample width
- DECIM_W, 16, decimation register width
- CW = $clog2(NCH), derived, channel index width

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- lia_x  in  NCH*DW  channel X results, channel i at [i*DW +: DW]
- lia_y  in  NCH*DW  channel Y results, same packing
- run  in  1  level; 1 = scheduler enabled
- decim  in  DECIM_W  snapshot period in clocks; 0 treated as 1
- cpu_ack  in  1  CPU has consumed the presented channel
- clr_ovr  in  1  one-cycle pulse; clears overrun
- out_x  out  DW  presented channel X
- out_y  out  DW  presented channel Y
- out_ch  out  CW  presented channel index
- out_valid  out  1  out_x/out_y/out_ch hold a channel not yet acked
- overrun  out  1  sticky; a tick was dropped during presentation
- busy  out  1  state is PRESENT

## Operation
- States: IDLE, WAIT, PRESENT.
- Tick counter cnt (DECIM_W bits):
  - Cleared while run=0.
  - Otherwise tick = (cnt ≥ max(decim,1)−1); cnt ← 0 on tick, else cnt+1.
  - Using ≥ makes a decim decrease take effect without a counter wrap.
- IDLE → WAIT when run=1.
- Any state → IDLE on the cycle after run=0:
  - out_valid ← 0, busy ← 0, cnt ← 0.
  - Shadow registers and out_x/out_y/out_ch retain their values.
  - overrun is unaffected.
- WAIT, on tick:
  - shadow ← lia_x/lia_y (all channels, same edge); ch ← first channel.
  - → PRESENT.
- PRESENT:
  - out_x/out_y/out_ch = shadow[ch], ch; out_valid=1.
  - cpu_ack=1 while out_valid=1: advance ch to the next channel, out_valid stays 1.
  - Ack on the last channel: out_valid ← 0 and → WAIT.
  - cpu_ack while out_valid=0 is ignored.
- A tick in PRESENT is dropped: the snapshot is not updated and overrun ← 1.
- overrun clears on clr_ovr. If a set and clr_ovr fall in the same cycle, the set wins.
- The tick counter runs continuously in WAIT and PRESENT, so the snapshot phase stays locked to decim.

## Timing
- Reset values: out_x=0, out_y=0, out_ch=0, out_valid=0, overrun=0, busy=0, state=IDLE, cnt=0, shadow=0.
- Tick cycle T in WAIT: out_valid=1 and out_ch=first channel at T+1. Data is lia_x/lia_y as sampled at the T edge.
- Ack at cycle A: the next channel appears at A+1. The CPU can drain one channel per clock; a full frame takes NCH cycles minimum.
- Ack on the last channel at A: out_valid=0 at A+1. A tick at A+1 is accepted (state is already WAIT).
- A tick in the same cycle as the last ack is dropped and counted as overrun (state is still PRESENT).
- run falling at cycle R: IDLE and out_valid=0 at R+1. run rising: the first tick follows after max(decim,1) clocks.
- All outputs are registered; no combinational input→output paths.

## Configuration
- Macro LIA_SCHED_CH_MASK_EN.
- Defined:
  - Adds port ch_mask (in, NCH), registered at each accepted tick.
  - PRESENT visits only channels with mask bit set, in ascending index.
  - A tick with an all-zero mask is consumed: stays in WAIT, no out_valid, no overrun.
- Undefined: port absent; all NCH channels are visited, 0..NCH−1.

## Test plan
- Reset release, run=1, decim=10, CPU acks each channel on the next cycle:
  - First out_valid 11 cycles after run (decim=10 clocks plus 1 cycle presentation latency).
  - out_ch steps 0..7 with the matching lia_x/lia_y values captured at the tick.
  - Then WAIT; overrun stays 0.
- decim=4, CPU never acks: channel 0 is held; overrun=1 after the 4th cycle; clr_ovr pulse in a tick cycle leaves overrun=1.
- Ack on channel 7 in the same cycle as a tick → overrun=1, no new frame. Ack on channel 7 one cycle before a tick → new frame, overrun=0.
- run dropped mid-frame at out_ch=3:
  - out_valid=0 next cycle; out_ch remains 3.
  - run reasserted with decim=0: a new frame starts, out_valid at the 2nd cycle.
- lia_x changed on the cycle after the tick: presented values equal the pre-change tick-edge values for all 8 channels.
- With LIA_SCHED_CH_MASK_EN, ch_mask=8'b1010_0100: out_ch sequence 2,5,7. ch_mask=0: no out_valid across 3 ticks, overrun=0.
